// File: rtl/piano_pkg.sv
// ---------------------------------------------------------------------------
// piano_pkg
//   Shared types, sizes and helpers for the piano input stage.
//   N_KEYS / N_OCT    : number of note buttons / octave switches
//   key_t / oct_t     : vector types for the button and switch groups
//   DEBOUNCE_DEFAULT  : debounce hold time in clk cycles (10 ms @ 50 MHz)
//   SUSTAIN_DEFAULT   : note sustain time in clk cycles (0.5 s @ 50 MHz)
//   lowest_set()      : isolate the lowest set bit (priority one-hot)
//   is_onehot()       : true when exactly one bit of a switch vector is set
// ---------------------------------------------------------------------------
package piano_pkg;

    localparam int N_KEYS = 4;
    localparam int N_OCT  = 7;

    typedef logic [N_KEYS-1:0] key_t;
    typedef logic [N_OCT-1:0]  oct_t;

    localparam int DEBOUNCE_DEFAULT = 500000;
    localparam int SUSTAIN_DEFAULT  = 25000000;

    // v & -v keeps only the least significant set bit, so bit 0 has priority.
    function automatic key_t lowest_set(input key_t v);
        return v & (~v + key_t'(1));
    endfunction

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    function automatic logic is_onehot(input oct_t v);
        return (v != '0) && ((v & (v - oct_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// ---------------------------------------------------------------------------
// debounce_cell
//   One-bit input conditioner: 2-flop synchroniser followed by a debounce
//   counter and a stable output bit. A new level must be seen on the
//   synchronised input for DEBOUNCE_CYCLES consecutive cycles before the
//   stable bit follows it; any return to the old level restarts the count.
// Ports
//   clk       in  1  system clock
//   i_rst_n   in  1  asynchronous active-low reset
//   i_raw     in  1  raw input, asynchronous to clk
//   o_stable  out 1  debounced level
// ---------------------------------------------------------------------------
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_stable
);

    logic [1:0]       r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync   <= '0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (r_sync[1] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                // Counter is cleared as the level is accepted, so it never
                // exceeds DEBOUNCE_CYCLES-1 and cannot wrap.
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/key_scan_debounce.sv
// ---------------------------------------------------------------------------
// key_scan_debounce
//   Input stage of the digital piano. Debounces 4 note buttons and 7 octave
//   switches and drives the one-hot pair (swBus, noteBus) for the note-clock
//   selector. Outputs are always one-hot or all-zero.
//   Optional feature macro: PIANO_SUSTAIN_EN -- when defined, noteBus keeps
//   its last note for SUSTAIN_CYCLES cycles after all buttons are released.
// Ports
//   clk          in  1  system clock
//   reset        in  1  asynchronous active-low reset
//   btn_raw      in  4  raw note buttons (active-high, async)
//   sw_raw       in  7  raw octave switches (active-high, async)
//   swBus        out 7  debounced octave select, one-hot or 0
//   noteBus      out 4  debounced note select, one-hot or 0
//   note_on      out 1  swBus != 0 and noteBus != 0
//   note_change  out 1  one-cycle pulse the cycle after {swBus,noteBus} changes
// ---------------------------------------------------------------------------
module key_scan_debounce
    import piano_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int SUSTAIN_CYCLES  = SUSTAIN_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    input  logic [6:0] sw_raw,
    output logic [6:0] swBus,
    output logic [3:0] noteBus,
    output logic       note_on,
    output logic       note_change
);

    if (DEBOUNCE_CYCLES < 1 || SUSTAIN_CYCLES < 0) begin : g_param_check
        $error("key_scan_debounce: DEBOUNCE_CYCLES must be >= 1 and SUSTAIN_CYCLES >= 0");
    end

    logic [N_KEYS-1:0] w_btn_stable;
    logic [N_OCT-1:0]  w_sw_stable;
    key_t              w_note_enc;
    key_t              w_note_next;
    oct_t              w_sw_next;

    key_t              r_note;
    oct_t              r_sw;
    logic              r_note_on;
    logic              r_note_change;
    logic [N_OCT+N_KEYS-1:0] r_prev_bus;

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_btn
            debounce_cell #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_cell (
                .clk      (clk),
                .i_rst_n  (reset),
                .i_raw    (btn_raw[gi]),
                .o_stable (w_btn_stable[gi])
            );
        end
        for (gi = 0; gi < N_OCT; gi++) begin : g_sw
            debounce_cell #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_cell (
                .clk      (clk),
                .i_rst_n  (reset),
                .i_raw    (sw_raw[gi]),
                .o_stable (w_sw_stable[gi])
            );
        end
    endgenerate

    assign w_note_enc = lowest_set(w_btn_stable);
    // Several octave switches at once is ambiguous: select no octave.
    assign w_sw_next  = is_onehot(w_sw_stable) ? w_sw_stable : '0;

`ifdef PIANO_SUSTAIN_EN
    localparam int SUS_W = $clog2(SUSTAIN_CYCLES + 1);

    logic [SUS_W-1:0] r_sus_cnt;
    logic [SUS_W-1:0] w_sus_cnt_next;

    // A live press always wins; the hold only runs while no button is down
    // and a note is still on the bus. Expiry is one cycle later than the
    // normal release clear for each held cycle.
    always_comb begin
        w_note_next    = w_note_enc;
        w_sus_cnt_next = '0;
        if (w_note_enc == '0 && r_note != '0) begin
            if (r_sus_cnt == SUS_W'(SUSTAIN_CYCLES)) begin
                w_note_next = '0;
            end else begin
                w_note_next    = r_note;
                w_sus_cnt_next = r_sus_cnt + SUS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sus_cnt <= '0;
        end else begin
            r_sus_cnt <= w_sus_cnt_next;
        end
    end
`else
    assign w_note_next = w_note_enc;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sw          <= '0;
            r_note        <= '0;
            r_note_on     <= 1'b0;
            r_prev_bus    <= '0;
            r_note_change <= 1'b0;
        end else begin
            r_sw          <= w_sw_next;
            r_note        <= w_note_next;
            r_note_on     <= (w_sw_next != '0) && (w_note_next != '0);
            // Compare the current buses with their value one cycle earlier,
            // so the pulse lands the cycle after the update and a joint
            // sw/note change gives only one pulse.
            r_prev_bus    <= {r_sw, r_note};
            r_note_change <= ({r_sw, r_note} != r_prev_bus);
        end
    end

    assign swBus       = r_sw;
    assign noteBus     = r_note;
    assign note_on     = r_note_on;
    assign note_change = r_note_change;

endmodule

// File: tb/tb_key_scan_debounce.sv
module tb_key_scan_debounce;

    localparam int D   = 4;
    localparam int SUS = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] btn_raw = '0;
    logic [6:0] sw_raw = '0;
    logic [6:0] swBus;
    logic [3:0] noteBus;
    logic       note_on;
    logic       note_change;

    int total = 0;
    int bad   = 0;

    key_scan_debounce #(
        .DEBOUNCE_CYCLES (D),
        .SUSTAIN_CYCLES  (SUS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .sw_raw      (sw_raw),
        .swBus       (swBus),
        .noteBus     (noteBus),
        .note_on     (note_on),
        .note_change (note_change)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Debounce: a bit is accepted once its last D synchronised samples
    // (taken since reset) all disagree with the accepted level.
    bit [10:0] m_pipe0, m_pipe1, m_stab;
    bit [10:0] m_win[$];
    bit [10:0] m_bus, m_bus_prev;   // {sw, note}
    bit        m_on, m_chg;
    bit [3:0]  m_last_nz;
    int        m_zero_run;

    function automatic bit [3:0] lowest_note(bit [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v[i]) return 4'(1 << i);
        return 4'h0;
    endfunction

    function automatic bit [6:0] sw_sel(bit [6:0] v);
        return ($countones(v) == 1) ? v : 7'h00;
    endfunction

    task automatic model_reset();
        m_pipe0 = '0; m_pipe1 = '0; m_stab = '0;
        m_win.delete();
        m_bus = '0; m_bus_prev = '0; m_on = 0; m_chg = 0;
        m_last_nz = '0; m_zero_run = 0;
    endtask

    task automatic model_step();
        bit [3:0] enc, note;
        bit [6:0] sw;
        bit       all_diff;
        m_chg      = (m_bus != m_bus_prev);
        m_bus_prev = m_bus;
        enc = lowest_note(m_stab[3:0]);
        sw  = sw_sel(m_stab[10:4]);
`ifdef PIANO_SUSTAIN_EN
        if (enc != 0) begin
            note = enc; m_last_nz = enc; m_zero_run = 0;
        end else begin
            m_zero_run++;
            note = (m_zero_run <= SUS) ? m_last_nz : 4'h0;
        end
`else
        note = enc;
`endif
        m_bus = {sw, note};
        m_on  = (sw != 0) && (note != 0);
        m_win.push_back(m_pipe1);
        if (m_win.size() > D) void'(m_win.pop_front());
        if (m_win.size() == D) begin
            for (int i = 0; i < 11; i++) begin
                all_diff = 1;
                for (int j = 0; j < D; j++)
                    if (m_win[j][i] == m_stab[i]) all_diff = 0;
                if (all_diff) m_stab[i] = ~m_stab[i];
            end
        end
        m_pipe1 = m_pipe0;
        m_pipe0 = {sw_raw, btn_raw};
    endtask

    // One clock: model advances on the edge, outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        #1;
    endtask

    task automatic settle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; model_reset();
        btn_raw = 4'hF; sw_raw = 7'h7F;
        #1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({swBus, noteBus, note_on, note_change} !== 13'h0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got sw=%h note=%h on=%b chg=%b want all 0",
                         i, swBus, noteBus, note_on, note_change);
            end
        end
        btn_raw = 4'h0; sw_raw = 7'h00;
        reset = 1'b1;
        settle(10);
        total++;
        if ({swBus, noteBus, note_on, note_change} !== 13'h0) begin
            bad++;
            $display("FAIL reset_release got sw=%h note=%h on=%b chg=%b want all 0",
                     swBus, noteBus, note_on, note_change);
        end
    endtask

    task automatic test_single_press();
        sw_raw = 7'h08; btn_raw = 4'h0;
        settle(12);
        btn_raw = 4'h2;
        settle(6);
        total++;
        if (noteBus !== 4'h0) begin
            bad++; $display("FAIL press_early got note=%h want 0", noteBus);
        end
        tick();
        total++;
        if (noteBus !== 4'h2 || note_on !== 1'b1 || swBus !== 7'h08 || note_change !== 1'b0) begin
            bad++;
            $display("FAIL press_latency got note=%h on=%b sw=%h chg=%b want note=2 on=1 sw=08 chg=0",
                     noteBus, note_on, swBus, note_change);
        end
        tick();
        total++;
        if (note_change !== 1'b1 || noteBus !== 4'h2) begin
            bad++; $display("FAIL press_pulse got chg=%b note=%h want chg=1 note=2", note_change, noteBus);
        end
        tick();
        total++;
        if (note_change !== 1'b0) begin
            bad++; $display("FAIL press_pulse_width got chg=%b want 0", note_change);
        end
    endtask

    task automatic test_glitch();
        btn_raw = 4'h0;
        settle(14);
        btn_raw = 4'h1;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) btn_raw = 4'h0;
            tick();
            total++;
            if (noteBus !== 4'h0 || note_change !== 1'b0) begin
                bad++;
                $display("FAIL glitch cyc=%0d got note=%h chg=%b want note=0 chg=0",
                         i, noteBus, note_change);
            end
        end
    endtask

    task automatic test_priority_onehot();
        btn_raw = 4'hC; sw_raw = 7'h08;
        settle(10);
        total++;
        if (noteBus !== 4'h4 || note_on !== 1'b1) begin
            bad++; $display("FAIL priority got note=%h on=%b want note=4 on=1", noteBus, note_on);
        end
        sw_raw = 7'h0A;
        settle(10);
        total++;
        if (swBus !== 7'h00 || note_on !== 1'b0 || noteBus !== 4'h4) begin
            bad++;
            $display("FAIL multi_sw got sw=%h on=%b note=%h want sw=00 on=0 note=4",
                     swBus, note_on, noteBus);
        end
    endtask

    task automatic test_reset_mid_debounce();
        btn_raw = 4'h0; sw_raw = 7'h08;
        settle(14);
        btn_raw = 4'h8;
        settle(2);
        reset = 1'b0; model_reset();
        tick();
        total++;
        if (noteBus !== 4'h0 || note_change !== 1'b0) begin
            bad++; $display("FAIL mid_rst_hold got note=%h chg=%b want 0 0", noteBus, note_change);
        end
        reset = 1'b1;
        settle(6);
        total++;
        if (noteBus !== 4'h0) begin
            bad++; $display("FAIL mid_rst_early got note=%h want 0", noteBus);
        end
        tick();
        total++;
        if (noteBus !== 4'h8 || swBus !== 7'h08 || note_on !== 1'b1) begin
            bad++;
            $display("FAIL mid_rst_arrival got note=%h sw=%h on=%b want note=8 sw=08 on=1",
                     noteBus, swBus, note_on);
        end
        total++;
        if ({swBus, noteBus} !== m_bus[10:0]) begin
            bad++; $display("FAIL mid_rst_model got bus=%h model=%h", {swBus, noteBus}, m_bus);
        end
    endtask

`ifdef PIANO_SUSTAIN_EN
    task automatic test_sustain();
        sw_raw = 7'h08; btn_raw = 4'h2;
        settle(12);
        btn_raw = 4'h0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            total++;
            if (noteBus !== ((i <= 14) ? 4'h2 : 4'h0)) begin
                bad++;
                $display("FAIL sustain_hold edge=%0d got note=%h want %h",
                         i, noteBus, (i <= 14) ? 4'h2 : 4'h0);
            end
        end
        btn_raw = 4'h2;
        settle(12);
        btn_raw = 4'h0;
        settle(3);
        btn_raw = 4'h1;
        settle(6);
        total++;
        if (noteBus !== 4'h2 || note_on !== 1'b1) begin
            bad++; $display("FAIL sustain_mid got note=%h on=%b want note=2 on=1", noteBus, note_on);
        end
        tick();
        total++;
        if (noteBus !== 4'h1) begin
            bad++; $display("FAIL sustain_cancel got note=%h want 1", noteBus);
        end
    endtask
`endif

    task automatic test_random();
        int hold_b = 0;
        int hold_s = 0;
        for (int c = 0; c < 600; c++) begin
            if (hold_b == 0) begin
                case ($urandom_range(0, 3))
                    0:       btn_raw = 4'h0;
                    1:       btn_raw = 4'($urandom);
                    default: btn_raw = 4'(1 << $urandom_range(0, 3));
                endcase
                hold_b = $urandom_range(1, 10);
            end
            if (hold_s == 0) begin
                if ($urandom_range(0, 3) == 0) sw_raw = 7'($urandom);
                else                           sw_raw = 7'(1 << $urandom_range(0, 6));
                hold_s = $urandom_range(1, 14);
            end
            hold_b--; hold_s--;
            tick();
            total++;
            if (swBus !== m_bus[10:4] || noteBus !== m_bus[3:0] ||
                note_on !== m_on || note_change !== m_chg) begin
                bad++;
                $display("FAIL random cyc=%0d got sw=%h note=%h on=%b chg=%b want sw=%h note=%h on=%b chg=%b",
                         c, swBus, noteBus, note_on, note_change,
                         m_bus[10:4], m_bus[3:0], m_on, m_chg);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_glitch();
        test_priority_onehot();
        test_reset_mid_debounce();
`ifdef PIANO_SUSTAIN_EN
        test_sustain();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
